// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional trailer checksum is enabled by defining IMEM_BOOT_CHECKSUM_EN.
package imem_boot_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_W     = BYTE_W * WORD_BYTES;

  // Header + data + trailer must sum to this value (mod 256).
  localparam logic [BYTE_W-1:0] CHK_TARGET = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Little-endian byte-to-word assembler; o_word already includes the byte
// being strobed this cycle, so o_word_full marks the cycle the word completes.
module imem_word_assembler
  import imem_boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_strobe,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_word_full,
  output logic [WORD_W-1:0] o_word
);

  logic [1:0]        r_cnt;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_word_next;

  always_comb begin
    w_word_next = r_word;
    if (i_strobe) begin
      w_word_next[r_cnt*BYTE_W +: BYTE_W] = i_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_strobe) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= w_word_next;
    end
  end

  assign o_word_full = i_strobe && (r_cnt == 2'(WORD_BYTES - 1));
  assign o_word      = w_word_next;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed image into instruction memory and
// holds the core in reset until it lands. Define IMEM_BOOT_CHECKSUM_EN for a trailer checksum.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WORD_W-1:0] wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra index bit so N == 2^ADDR_W compares without wrapping.
  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  state_e            r_state;
  state_e            w_state_next;
  logic [IDX_W-1:0]  r_index;
  logic [IDX_W-1:0]  r_count;
  logic [IDX_W-1:0]  w_index_inc;
  logic              w_xfer;
  logic              w_hdr_bad;
  logic              w_last;
  logic              w_asm_clear;
  logic              w_asm_strobe;
  logic              w_word_full;
  logic [WORD_W-1:0] w_word;
  logic              w_rx_ready_nx;
  logic              w_busy_nx;
  logic              w_done_nx;
  logic              w_err_nx;
  logic              w_we_nx;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [BYTE_W-1:0] r_sum;
  logic [BYTE_W-1:0] w_sum_tot;
`endif

  assign w_xfer       = rx_valid & rx_ready;
  assign w_hdr_bad    = (rx_data == '0) || (32'(rx_data) > DEPTH);
  assign w_index_inc  = r_index + IDX_W'(1);
  assign w_last       = (w_index_inc == r_count);
  assign w_asm_clear  = w_xfer && (r_state == ST_HDR);
  assign w_asm_strobe = w_xfer && (r_state == ST_DATA);
`ifdef IMEM_BOOT_CHECKSUM_EN
  assign w_sum_tot    = r_sum + rx_data;
`endif

  imem_word_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_asm_clear),
    .i_strobe    (w_asm_strobe),
    .i_byte      (rx_data),
    .o_word_full (w_word_full),
    .o_word      (w_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus next-cycle values of the state-decoded outputs.
  always_comb begin
    w_state_next  = r_state;
    w_rx_ready_nx = 1'b0;
    w_busy_nx     = 1'b0;
    w_done_nx     = 1'b0;
    w_err_nx      = 1'b0;
    w_we_nx       = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_HDR;
      ST_HDR:   if (w_xfer) w_state_next = w_hdr_bad ? ST_ERROR : ST_DATA;
      ST_DATA:  if (w_word_full) w_state_next = ST_WRITE;
      ST_WRITE: begin
        if (w_last) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
          w_state_next = ST_CHK;
`else
          w_state_next = ST_DONE;
`endif
        end else begin
          w_state_next = ST_DATA;
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      ST_CHK:   if (w_xfer) w_state_next = (w_sum_tot == CHK_TARGET) ? ST_DONE : ST_ERROR;
`endif
      ST_DONE:  if (start) w_state_next = ST_HDR;
      ST_ERROR: if (start) w_state_next = ST_HDR;
      default:  w_state_next = ST_IDLE;
    endcase
    w_rx_ready_nx = (w_state_next inside {ST_HDR, ST_DATA, ST_CHK});
    w_busy_nx     = (w_state_next inside {ST_HDR, ST_DATA, ST_WRITE, ST_CHK});
    w_done_nx     = (w_state_next == ST_DONE);
    w_err_nx      = (w_state_next == ST_ERROR);
    w_we_nx       = (w_state_next == ST_WRITE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_ready   <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      r_index    <= '0;
      r_count    <= '0;
    end else begin
      rx_ready   <= w_rx_ready_nx;
      we         <= w_we_nx;
      core_rst_n <= w_done_nx;
      busy       <= w_busy_nx;
      done       <= w_done_nx;
      err        <= w_err_nx;
      if (w_asm_clear) begin
        r_count <= IDX_W'(rx_data);
        r_index <= '0;
      end
      // Write address/data are captured with the completing byte and held otherwise.
      if (w_word_full) begin
        wdata <= w_word;
        waddr <= r_index[ADDR_W-1:0];
      end
      if (r_state == ST_WRITE) begin
        r_index <= w_index_inc;
      end
    end
  end

`ifdef IMEM_BOOT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (w_asm_clear) begin
      r_sum <= rx_data;
    end else if (w_asm_strobe) begin
      r_sum <= w_sum_tot;
    end
  end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader; expected writes and final status are
// queued by the stimulus and popped by an independent monitor.
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t        wr_q[$];
  logic [2:0] st_q[$];   // {done, err, core_rst_n}
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         last_we_cyc = 0;
  logic       fin_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write and every entry into DONE/ERROR is matched against the queues.
  always @(negedge clk) begin
    if (rst && we) begin
      if (wr_q.size() == 0) begin
        check("unexpected_we", 32'(waddr), 32'hFFFF_FFFF);
      end else begin
        check("waddr", 32'(waddr), 32'(wr_q[0].a));
        check("wdata", wdata, wr_q[0].d);
        void'(wr_q.pop_front());
      end
      last_we_cyc <= cyc;
    end
    if (rst && (done || err) && !fin_q) begin
      if (st_q.size() == 0) begin
        check("unexpected_status", 32'({done, err, core_rst_n}), 32'hFFFF_FFFF);
      end else begin
        check("status", 32'({done, err, core_rst_n}), 32'(st_q[0]));
        void'(st_q.pop_front());
      end
`ifndef IMEM_BOOT_CHECKSUM_EN
      if (done) check("done_latency", 32'(cyc - last_we_cyc), 32'd1);
`endif
    end
    fin_q <= done | err;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    end else begin
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic wait_fin(input string name);
    int n;
    n = 0;
    while (!(done || err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(done || err)) check({name, "_timeout"}, 32'({done, err}), 32'd1);
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
    check({tag, "_we"},         32'(we),         32'd0);
    check({tag, "_waddr"},      32'(waddr),      32'd0);
    check({tag, "_wdata"},      wdata,           32'd0);
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_err"},        32'(err),        32'd0);
  endtask

  initial begin : stim
    logic [31:0] w;
    logic [7:0]  csum;

    repeat (3) @(negedge clk);
    check_all_reset("reset");
    rst = 1'b1;
    @(negedge clk);

    // Single word: 01 | 93 00 50 00 (| 1C)
    wr_q.push_back('{a: '0, d: 32'h0050_0093});
    st_q.push_back(3'b101);
    pulse_start();
    check("start_rx_ready", 32'(rx_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    send_byte(8'h01, 0);
    send_word(32'h0050_0093, 0);
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_byte(8'h1C, 0);
`endif
    wait_fin("single");
    check("single_done", 32'(done), 32'd1);
    check("single_core_rst_n", 32'(core_rst_n), 32'd1);

    // Bytes offered in DONE are not consumed.
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("done_rx_ready", 32'(rx_ready), 32'd0);
    check("done_hold", 32'(done), 32'd1);
    rx_valid = 1'b0;

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Bad trailer, then correct image.
    wr_q.push_back('{a: '0, d: 32'h0050_0093});
    st_q.push_back(3'b010);
    pulse_start();
    send_byte(8'h01, 0);
    send_word(32'h0050_0093, 1);
    send_byte(8'h1D, 0);
    wait_fin("bad_chk");
    check("bad_chk_err", 32'(err), 32'd1);
    check("bad_chk_done", 32'(done), 32'd0);
    wr_q.push_back('{a: '0, d: 32'h0050_0093});
    st_q.push_back(3'b101);
    pulse_start();
    send_byte(8'h01, 0);
    send_word(32'h0050_0093, 1);
    send_byte(8'h1C, 0);
    wait_fin("good_chk");
    check("good_chk_done", 32'(done), 32'd1);
`endif

    // Reload from DONE into a full-depth image with stalls.
    pulse_start();
    check("reload_core_rst_n", 32'(core_rst_n), 32'd0);
    check("reload_rx_ready", 32'(rx_ready), 32'd1);
    check("reload_done", 32'(done), 32'd0);
    for (int i = 0; i < 16; i++) begin
      wr_q.push_back('{a: ADDR_W'(i), d: 32'(i) * 32'h0101_0101});
    end
    st_q.push_back(3'b101);
    csum = 8'h10;
    send_byte(8'h10, int'($urandom_range(0, 3)));
    for (int i = 0; i < 16; i++) begin
      w = 32'(i) * 32'h0101_0101;
      csum = csum + 8'(4 * i);
      send_word(w, 3);
      if (i == 1) begin
        pulse_start();
        check("start_ignored_busy", 32'(busy), 32'd1);
      end
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_byte(8'h00 - csum, 2);
`endif
    wait_fin("full");
    check("full_done", 32'(done), 32'd1);

    // Header 0 and header 17 are rejected without writes.
    st_q.push_back(3'b010);
    pulse_start();
    send_byte(8'h00, 0);
    wait_fin("hdr0");
    check("hdr0_err", 32'(err), 32'd1);
    check("hdr0_core_rst_n", 32'(core_rst_n), 32'd0);
    pulse_start();
    check("err_cleared", 32'(err), 32'd0);
    st_q.push_back(3'b010);
    send_byte(8'h11, 1);
    wait_fin("hdr17");
    check("hdr17_err", 32'(err), 32'd1);
    check("hdr17_core_rst_n", 32'(core_rst_n), 32'd0);

    // Reset after two data bytes: partial word must never be written.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b0;
    @(negedge clk);
    check_all_reset("midrst");
    rst = 1'b1;
    rx_data  = 8'h33;
    rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_rx_ready", 32'(rx_ready), 32'd0);
    check("idle_core_rst_n", 32'(core_rst_n), 32'd0);
    rx_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("st_q_drained", 32'(st_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-stream boot loader that sits upstream of the single-cycle RISC-V core's instruction memory. It accepts a program as a valid/ready byte stream and assembles little-endian 32-bit words. It writes them sequentially into instruction memory from address 0 and holds the core in reset until the load completes. Malformed or oversized images are rejected, and the core is kept in reset.

## Interface
- `ADDR_W`, 4, instruction-memory word-address width; legal range 1..8.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `start`  in  1  begin a load; sampled only in IDLE, DONE, ERROR.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts the byte this cycle; transfer = `rx_valid & rx_ready`.
- `we`  out  1  instruction-memory write enable, one-cycle pulse per word.
- `waddr`  out  ADDR_W  word address for the write.
- `wdata`  out  32  assembled word.
- `core_rst_n`  out  1  active-low reset to the core; 1 only in DONE.
- `busy`  out  1  load in progress (HDR, DATA, WRITE, CHK).
- `done`  out  1  image loaded successfully.
- `err`  out  1  image rejected.

## Operation
- States: IDLE, HDR, DATA, WRITE, CHK, DONE, ERROR.
- IDLE:
  - `rx_ready` is 0; `core_rst_n` is 0.
  - `start` goes to HDR.
- HDR:
  - `rx_ready` is 1.
  - The first accepted byte is the word count N.
  - If N==0 or N>2^ADDR_W, go to ERROR. Otherwise latch N, clear the word index and byte counter, and go to DATA.
- DATA:
  - `rx_ready` is 1.
  - Accepted byte k (0..3) goes to `wdata[8k+7:8k]`.
  - On acceptance of byte 3, go to WRITE.
- WRITE:
  - `rx_ready` is 0.
  - `we` is 1 for exactly one cycle, with `waddr` set to the index and `wdata` set to the assembled word.
  - Then the index increments.
  - If index+1==N, go to CHK when the checksum is enabled, otherwise to DONE.
  - If index+1!=N, return to DATA.
- CHK: accepts one trailer byte; see Configuration.
- DONE:
  - `done` is 1 and `core_rst_n` is 1; `rx_ready` is 0.
  - `start` goes to HDR and drops `core_rst_n` the next cycle (reload).
- ERROR:
  - `err` is 1 and `core_rst_n` is 0; `rx_ready` is 0.
  - `start` goes to HDR and clears `err`.
- Bytes presented while `rx_ready`=0 are not consumed. Gaps in `rx_valid` stall the FSM indefinitely, with no timeout.
- `start` is ignored in HDR, DATA, WRITE and CHK.
- Reset mid-load:
  - FSM returns to IDLE and all counters clear.
  - Words already written remain in memory, but the core stays in reset.
- Word index width is ADDR_W+1, so the comparison with N=2^ADDR_W does not wrap.

## Timing
- Reset values: `rx_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `core_rst_n`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- All outputs are registered or decoded from state, with no combinational path from `rx_valid` to `rx_ready`.
- `start` to `rx_ready`=1: 1 cycle.
- Accepting the 4th byte of a word to `we`=1: 1 cycle.
- Minimum 5 cycles per word (4 accepts + 1 WRITE).
- Last WRITE (no checksum) to `done`=1 / `core_rst_n`=1: 1 cycle.
- CHK byte accept to DONE or ERROR: 1 cycle.
- `wdata` and `waddr` hold their last values outside WRITE.

## Configuration
- `IMEM_BOOT_CHECKSUM_EN` defined:
  - An 8-bit running sum (mod 256) covers the header and all data bytes.
  - A trailer byte is accepted in CHK.
  - If sum+trailer==0x00 (mod 256), go to DONE; otherwise go to ERROR.
- `IMEM_BOOT_CHECKSUM_EN` undefined:
  - No accumulator and no CHK state; DONE directly after the last WRITE.
  - A trailer byte is not consumed.

## Structure
- Shared package `imem_boot_pkg`: state enum, `BYTE_W`=8, `WORD_BYTES`=4, checksum target 8'h00.
- One sub-module, `imem_word_assembler`:
  - 2-bit byte counter and 32-bit shift/insert register.
  - Inputs: byte strobe and clear. Outputs: `word_full`, `word`.

## Test plan
- **Single word:** `start`, then stream 01 93 00 50 00 (+1C with checksum). Expect one `we` pulse with `waddr`=0 and `wdata`=0x00500093, then `done`=1 and `core_rst_n`=1.
- **Full depth with stalls:** ADDR_W=4, N=16, words 0..15 = index×0x01010101, with random `rx_valid` gaps. Expect 16 writes at `waddr` 0..15 with matching data, and `done`.
- **Header errors:** header 0x00 -> `err`=1, `core_rst_n`=0, no `we`. Header 0x11 (17) -> same.
- **Checksum (macro on):** same as the single-word case but trailer 0x1D -> `err`=1, `done`=0. A subsequent `start` plus the correct image -> `done`=1.
- **Reset mid-load:** assert `rst`=0 after 2 data bytes. Expect all outputs at reset values next cycle, and no `we` from the partial word.
- **Reload:** from DONE, `start`. Expect `core_rst_n`=0 next cycle and `rx_ready`=1; `start` during DATA is ignored.
